// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module   : data_cache
// Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//            one-word lines, zero-cycle read hits and load hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module data_cache #(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_SIZE  = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic                 write_enable,
  input  logic [DATA_SIZE-1:0] write_data,
  output logic [DATA_SIZE-1:0] read_data,
  output logic                 hit,
  output logic                 ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int C_LINES = 1 << INDEX_BITS;
  localparam int C_TAG_W = ADDR_SIZE - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_MISS  = 2'd1,
    WRITE_THRU = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [C_LINES-1:0]   r_valid;
  logic [C_TAG_W-1:0]   r_tag  [C_LINES];
  logic [DATA_SIZE-1:0] r_data [C_LINES];
  logic                 r_refill;
  logic [31:0]          r_hit_cnt;
  logic [31:0]          r_miss_cnt;

  logic [INDEX_BITS-1:0] w_index;
  logic [C_TAG_W-1:0]    w_tag;
  logic                  w_fill;
  logic                  w_write_update;
  logic                  w_hit_inc;
  logic                  w_miss_inc;
  logic                  w_unused;

  // Byte-offset bits never select anything: lines are one word wide.
  assign w_unused = ^addr[1:0];

  assign w_index   = addr[INDEX_BITS+1:2];
  assign w_tag     = addr[ADDR_SIZE-1:INDEX_BITS+2];
  assign hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign read_data = r_data[w_index];
  assign mem_addr  = {addr[ADDR_SIZE-1:2], 2'b00};
  assign mem_wdata = write_data;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // State register; reset abandons any RAM transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus handshake outputs and array/counter strobes.
  always_comb begin
    w_next_state   = r_state;
    ready          = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    w_fill         = 1'b0;
    w_write_update = 1'b0;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (write_enable) begin
            w_next_state = WRITE_THRU;
          end else if (hit) begin
            ready     = 1'b1;
            // The replay of a just-refilled miss is not a genuine hit.
            w_hit_inc = ~r_refill;
          end else begin
            w_next_state = READ_MISS;
            w_miss_inc   = 1'b1;
          end
        end
      end
      READ_MISS: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      WRITE_THRU: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        ready   = mem_ready;
        if (mem_ready) begin
          // No allocation on a store miss; only an already-resident line is updated.
          w_write_update = hit;
          w_next_state   = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Valid bits are the only array state that must be cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Tag and data arrays: refill on a completed miss, update on a store hit.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= mem_rdata;
    end else if (w_write_update) begin
      r_data[w_index] <= write_data;
    end
  end

  // Refill flag marks the single IDLE cycle that replays a filled miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refill <= 1'b0;
    end else if (w_fill) begin
      r_refill <= 1'b1;
    end else if (r_state == IDLE) begin
      r_refill <= 1'b0;
    end
  end

  // Load hit/miss counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_hit_inc) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_inc) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_cache
// Brief    : Self-checking bench for data_cache: vector table of accesses,
//            expected load data queued at issue and popped at completion,
//            behavioural RAM with programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        hit;
  logic        ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    logic [31:0] exp_hc;
    logic [31:0] exp_mc;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] exp_q [$];
  logic [31:0] ram_mem [logic [31:0]];
  int          ram_lat  = 1;
  int          wait_cnt = 0;

  data_cache dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .hit          (hit),
    .ready        (ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: answers a request after ram_lat cycles of mem_req.
  always @(negedge clk) begin
    if (mem_req && !mem_ready) begin
      if (wait_cnt >= ram_lat - 1) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        if (mem_we) begin
          ram_mem[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = ram_mem.exists(mem_addr) ? ram_mem[mem_addr] : 32'd0;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one access, follow it to completion, check handshake and counters.
  task automatic run_vec(input vec_t v, input string name);
    int          waits;
    int          reqs;
    int          exp_waits;
    bit          done;
    logic [31:0] exp_d;
    ram_lat = v.lat;
    @(negedge clk);
    req_valid    = 1'b1;
    addr         = v.addr;
    write_enable = v.we;
    write_data   = v.wdata;
    if (!v.we) exp_q.push_back(v.exp_rdata);
    #1;
    chk({name, " hit"}, {31'd0, hit}, {31'd0, v.exp_hit});
    waits = 0;
    reqs  = 0;
    done  = 1'b0;
    while (!done && waits < 40) begin
      if (mem_req) begin
        reqs++;
        chk({name, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
        chk({name, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
        if (v.we) chk({name, " mem_wdata"}, mem_wdata, v.wdata);
      end
      if (ready) begin
        done = 1'b1;
      end else begin
        waits++;
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      if (!v.we) begin
        if (exp_q.size() == 0) begin
          chk({name, " queue empty"}, 32'd0, 32'd1);
        end else begin
          exp_d = exp_q.pop_front();
          chk({name, " read_data"}, read_data, exp_d);
        end
      end
      if (v.we)            exp_waits = v.lat;
      else if (v.exp_hit)  exp_waits = 0;
      else                 exp_waits = v.lat + 1;
      chk({name, " stall cycles"}, waits, exp_waits);
      chk({name, " mem_req cycles"}, reqs, (!v.we && v.exp_hit) ? 0 : v.lat);
    end
    @(posedge clk);
    #1;
    chk({name, " hit_cnt"}, hit_cnt, v.exp_hc);
    chk({name, " miss_cnt"}, miss_cnt, v.exp_mc);
  endtask

  initial begin
    // we, addr, wdata, lat, exp_hit, exp_rdata, exp_hit_cnt, exp_miss_cnt
    vecs[0]  = '{1'b0, 32'h40,  32'h0,         3, 1'b0, 32'hDEADBEEF, 32'd0, 32'd1};
    vecs[1]  = '{1'b0, 32'h40,  32'h0,         3, 1'b1, 32'hDEADBEEF, 32'd1, 32'd1};
    vecs[2]  = '{1'b0, 32'h80,  32'h0,         2, 1'b0, 32'hCAFEF00D, 32'd1, 32'd2};
    vecs[3]  = '{1'b0, 32'h40,  32'h0,         1, 1'b0, 32'hDEADBEEF, 32'd1, 32'd3};
    vecs[4]  = '{1'b1, 32'h40,  32'h12345678,  2, 1'b1, 32'h0,        32'd1, 32'd3};
    vecs[5]  = '{1'b0, 32'h40,  32'h0,         1, 1'b1, 32'h12345678, 32'd2, 32'd3};
    vecs[6]  = '{1'b1, 32'h100, 32'hA5A5A5A5,  1, 1'b0, 32'h0,        32'd2, 32'd3};
    vecs[7]  = '{1'b0, 32'h100, 32'h0,         2, 1'b0, 32'hA5A5A5A5, 32'd2, 32'd4};
    vecs[8]  = '{1'b0, 32'h100, 32'h0,         1, 1'b1, 32'hA5A5A5A5, 32'd3, 32'd4};
    vecs[9]  = '{1'b0, 32'h44,  32'h0,         1, 1'b0, 32'h11112222, 32'd3, 32'd5};
    vecs[10] = '{1'b0, 32'h47,  32'h0,         1, 1'b1, 32'h11112222, 32'd4, 32'd5};
    vecs[11] = '{1'b1, 32'h44,  32'h33334444,  3, 1'b1, 32'h0,        32'd4, 32'd5};
    vecs[12] = '{1'b0, 32'h40,  32'h0,         2, 1'b0, 32'h12345678, 32'd4, 32'd6};

    ram_mem[32'h40]  = 32'hDEADBEEF;
    ram_mem[32'h44]  = 32'h11112222;
    ram_mem[32'h80]  = 32'hCAFEF00D;
    ram_mem[32'h100] = 32'h00000000;

    rst          = 1'b1;
    req_valid    = 1'b0;
    addr         = 32'h40;
    write_enable = 1'b0;
    write_data   = 32'd0;
    mem_rdata    = 32'd0;
    mem_ready    = 1'b0;

    // Reset state with RAM idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset hit", {31'd0, hit}, 32'd0);
    chk("reset hit_cnt", hit_cnt, 32'd0);
    chk("reset miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    // Vector table: cold miss, hit, conflict evictions, stores, offsets.
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted two cycles into a read miss.
    ram_lat = 10;
    @(negedge clk);
    req_valid    = 1'b1;
    addr         = 32'h80;
    write_enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midmiss mem_req before reset", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midmiss mem_req", {31'd0, mem_req}, 32'd0);
    chk("midmiss ready", {31'd0, ready}, 32'd0);
    chk("midmiss hit_cnt", hit_cnt, 32'd0);
    chk("midmiss miss_cnt", miss_cnt, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec('{1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h12345678, 32'd0, 32'd1}, "post-reset reload");

    // Miss counter wrap.
    @(negedge clk);
    req_valid = 1'b0;
    force dut.r_miss_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_miss_cnt;
    #1;
    chk("wrap preset", miss_cnt, 32'hFFFF_FFFF);
    run_vec('{1'b0, 32'h80, 32'h0, 1, 1'b0, 32'hCAFEF00D, 32'd0, 32'd0}, "wrap");

    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
